if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues word fetches to instruction
//  memory over a req/ack handshake and presents PC_F/Instr_F/PC_Plus4_F to the
//  IF/ID pipeline register. Supports hazard stalls, branch/jump redirects
//  resolved in ID, and variable memory latency.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  reset       in   1   synchronous, active-high reset
//  StallF      in   1   hazard unit: hold the presented instruction
//  PCSrcD      in   1   branch taken in ID (redirect + flush)
//  PCBranchD   in   32  branch target
//  JumpD       in   1   jump in ID (redirect + flush)
//  PCJumpD     in   32  jump target
//  IMemReq     out  1   fetch request
//  IMemAddr    out  32  fetch address, stable while IMemReq=1 and no ack
//  IMemAck     in   1   response valid; may be high in the same cycle as IMemReq
//  IMemRData   in   32  instruction word, valid when IMemAck=1
//  PC_F        out  32  PC of presented instruction
//  Instr_F     out  32  presented instruction
//  PC_Plus4_F  out  32  PC_F + 4
//  Valid_F     out  1   PC_F/Instr_F/PC_Plus4_F hold a live instruction
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=IDLE, Valid_F=0, Instr_F=0, PC_F=RESET_PC,
//    PC_Plus4_F=RESET_PC+4, req_addr=0. IMemReq=0 during the reset cycle.
//  - redirect = PCSrcD|JumpD; target = PCSrcD ? PCBranchD : PCJumpD (branch wins).
//    Targets are used verbatim. Redirect overrides StallF.
//  - slot_free = !Valid_F | !StallF. Consume = Valid_F & !StallF. On consume
//    without a same-edge capture, Valid_F<=0.
//  - Capture (on ack, kept): Instr_F<=IMemRData, PC_F<=fetch addr,
//    PC_Plus4_F<=fetch addr+4, Valid_F<=1, pc<=fetch addr+4.
//  - Any redirect: Valid_F<=0 and pc<=target on that edge.
//  - All outputs are registered. Exception: IMemReq/IMemAddr are combinational
//    from state, pc, req_addr, slot_free and redirect.
//  - States:
//    IDLE: no request outstanding, IMemAddr=pc.
//      IMemReq = slot_free & !redirect.
//      redirect -> IDLE.
//      req & ack -> capture, IDLE.
//      req & !ack -> req_addr<=pc, BUSY.
//      !slot_free -> hold all outputs, IDLE.
//    BUSY: IMemReq=1, IMemAddr=req_addr, Valid_F=0.
//      ack & !redirect -> capture, IDLE.
//      ack & redirect -> discard data, IDLE.
//      !ack & redirect -> DRAIN.
//      else stay in BUSY.
//    DRAIN: IMemReq=1, IMemAddr=req_addr (outstanding request finishes).
//      Further redirects update pc (the last one wins).
//      ack -> discard data, IDLE.
//  - The memory never sees IMemReq drop or IMemAddr change before ack.
//  - Latency: with a zero-wait memory, Valid_F rises one cycle after the
//    request cycle. Throughput is 1 instruction/cycle while StallF=0.
//  - Width: pc+4 is 32-bit modulo 2^32. 0xFFFF_FFFC+4 = 0x0000_0000.
//  - Ack while state=IDLE and IMemReq=0 is ignored.
//  - Reset mid-BUSY/DRAIN: immediate return to the reset values. Any late ack
//    is ignored by IDLE because IMemReq=0 in the reset cycle.
//  - A redirect in the same cycle as reset: reset wins.
// TESTING
//  1. RESET_PC=0x0040_0000, IMemAck tied 1, StallF=0 -> IMemAddr 0x00400000,
//     0x00400004, ... in consecutive cycles; PC_F follows one cycle later; Valid_F=1 steady.
//  2. StallF=1 for 3 cycles with Valid_F=1 -> PC_F/Instr_F unchanged, IMemReq=0,
//     pc not advanced; fetch resumes the cycle StallF drops.
//  3. Ack delayed 2 cycles -> IMemReq and IMemAddr held 3 cycles, Valid_F=0
//     meanwhile, capture on the ack edge, Valid_F=1 the next cycle.
//  4. PCSrcD=1, PCBranchD=0x100 while BUSY (addr 0x20) and no ack -> DRAIN;
//     ack data 0xDEADBEEF is not presented; next IMemAddr=0x100.
//  5. PCSrcD=1 and JumpD=1 together (targets 0x200/0x300) -> next fetch at
//     0x200, Valid_F=0 for that edge.
//  6. pc=0xFFFF_FFFC, zero-wait -> PC_Plus4_F=0x0, next IMemAddr=0x0.
//  7. reset asserted while BUSY -> the next cycle matches the reset values,
//     IMemReq=0 during reset, and an ack arriving then is ignored.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage owning the PC, issuing req/ack word fetches
// and presenting PC_F/Instr_F/PC_Plus4_F to the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_Plus4_F,
    output logic        Valid_F
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    state_t state, state_n;
    logic [31:0] pc, req_addr, target;
    logic redirect, slot_free, capture, load_req;

    always_comb begin
        redirect  = PCSrcD || JumpD;
        target    = PCSrcD ? PCBranchD : PCJumpD;
        slot_free = !Valid_F || !StallF;
        // Reset gating keeps a late ack from being mistaken for a live fetch.
        IMemReq   = !reset && (state != IDLE || (slot_free && !redirect));
        IMemAddr  = state == IDLE ? pc : req_addr;
        capture   = IMemReq && IMemAck && !redirect && state != DRAIN;
        load_req  = state == IDLE && IMemReq && !IMemAck;
        state_n   = state == IDLE ? (load_req ? BUSY : IDLE) :
                    IMemAck ? IDLE :
                    (state == BUSY && redirect) ? DRAIN : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_addr   <= 32'h0;
            Valid_F    <= 1'b0;
            Instr_F    <= 32'h0;
            PC_F       <= RESET_PC;
            PC_Plus4_F <= RESET_PC + 32'd4;
        end else begin
            state <= state_n;
            if (load_req)
                req_addr <= pc;
            if (Valid_F && !StallF)
                Valid_F <= 1'b0;
            if (capture) begin
                Instr_F    <= IMemRData;
                PC_F       <= IMemAddr;
                PC_Plus4_F <= IMemAddr + 32'd4;
                Valid_F    <= 1'b1;
                pc         <= IMemAddr + 32'd4;
            end
            if (redirect) begin
                Valid_F <= 1'b0;
                pc      <= target;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vector table plus a short stall/redirect sequence
// for the if_fetch stage with RESET_PC=0x0040_0000.
module tb_if_fetch;
    logic clk = 1'b0, reset, StallF, PCSrcD, JumpD, IMemAck;
    logic [31:0] PCBranchD, PCJumpD, IMemRData;
    logic IMemReq, Valid_F;
    logic [31:0] IMemAddr, PC_F, Instr_F, PC_Plus4_F;
    int checks = 0, errors = 0;

    if_fetch #(.RESET_PC(32'h0040_0000)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
        .IMemRData(IMemRData), .PC_F(PC_F), .Instr_F(Instr_F),
        .PC_Plus4_F(PC_Plus4_F), .Valid_F(Valid_F)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, psrc;
        logic [31:0] pbr;
        logic        jmp;
        logic [31:0] pj;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t v[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic psrc, input logic [31:0] pbr,
                         input logic jmp, input logic [31:0] pj, input logic ack, input logic [31:0] rdata);
        reset = rst; StallF = stall; PCSrcD = psrc; PCBranchD = pbr;
        JumpD = jmp; PCJumpD = pj; IMemAck = ack; IMemRData = rdata;
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pcf, input logic [31:0] instr);
        check({tag, " req"}, {31'b0, IMemReq}, {31'b0, req});
        check({tag, " addr"}, IMemAddr, addr);
        check({tag, " valid"}, {31'b0, Valid_F}, {31'b0, valid});
        check({tag, " pc_f"}, PC_F, pcf);
        check({tag, " instr"}, Instr_F, instr);
        check({tag, " pc_plus4"}, PC_Plus4_F, pcf + 32'd4);
    endtask

    initial begin
        // rst stall psrc pbr jmp pj ack rdata | req addr valid pc_f instr
        v[0]  = '{1,0,0,0,0,0,1,32'h11,          0,32'h0040_0000,0,32'h0040_0000,32'h0};
        v[1]  = '{0,0,0,0,0,0,1,32'h11,          1,32'h0040_0000,0,32'h0040_0000,32'h0};
        v[2]  = '{0,0,0,0,0,0,1,32'h22,          1,32'h0040_0004,1,32'h0040_0000,32'h11};
        v[3]  = '{0,0,0,0,0,0,1,32'h33,          1,32'h0040_0008,1,32'h0040_0004,32'h22};
        v[4]  = '{0,1,0,0,0,0,1,32'hE1,          0,32'h0040_000C,1,32'h0040_0008,32'h33};
        v[5]  = '{0,1,0,0,0,0,1,32'hE2,          0,32'h0040_000C,1,32'h0040_0008,32'h33};
        v[6]  = '{0,1,0,0,0,0,1,32'hE3,          0,32'h0040_000C,1,32'h0040_0008,32'h33};
        v[7]  = '{0,0,0,0,0,0,1,32'h44,          1,32'h0040_000C,1,32'h0040_0008,32'h33};
        v[8]  = '{0,0,0,0,0,0,0,32'hF0,          1,32'h0040_0010,1,32'h0040_000C,32'h44};
        v[9]  = '{0,0,0,0,0,0,0,32'hF1,          1,32'h0040_0010,0,32'h0040_000C,32'h44};
        v[10] = '{0,0,0,0,0,0,1,32'h55,          1,32'h0040_0010,0,32'h0040_000C,32'h44};
        v[11] = '{0,0,0,0,0,0,0,32'h0,           1,32'h0040_0014,1,32'h0040_0010,32'h55};
        v[12] = '{0,0,1,32'h100,0,0,0,32'h0,     1,32'h0040_0014,0,32'h0040_0010,32'h55};
        v[13] = '{0,0,0,0,0,0,0,32'h0,           1,32'h0040_0014,0,32'h0040_0010,32'h55};
        v[14] = '{0,0,0,0,0,0,1,32'hDEAD_BEEF,   1,32'h0040_0014,0,32'h0040_0010,32'h55};
        v[15] = '{0,0,0,0,0,0,1,32'h66,          1,32'h100,0,32'h0040_0010,32'h55};
        v[16] = '{0,0,1,32'h200,1,32'h300,1,32'h77, 0,32'h104,1,32'h100,32'h66};
        v[17] = '{0,0,0,0,0,0,1,32'h88,          1,32'h200,0,32'h100,32'h66};
        v[18] = '{0,0,0,0,1,32'hFFFF_FFFC,1,32'h0, 0,32'h204,1,32'h200,32'h88};
        v[19] = '{0,0,0,0,0,0,1,32'h99,          1,32'hFFFF_FFFC,0,32'h200,32'h88};
        v[20] = '{0,0,0,0,0,0,1,32'hAA,          1,32'h0,1,32'hFFFF_FFFC,32'h99};
        v[21] = '{0,0,0,0,0,0,0,32'h0,           1,32'h4,1,32'h0,32'hAA};
        v[22] = '{0,0,0,0,0,0,0,32'h0,           1,32'h4,0,32'h0,32'hAA};
        v[23] = '{1,0,1,32'h500,0,0,1,32'hBB,    0,32'h4,0,32'h0,32'hAA};
        v[24] = '{0,0,0,0,0,0,0,32'h0,           1,32'h0040_0000,0,32'h0040_0000,32'h0};

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 25; i++) begin
            drive(v[i].rst, v[i].stall, v[i].psrc, v[i].pbr, v[i].jmp, v[i].pj, v[i].ack, v[i].rdata);
            #3;
            check_all($sformatf("row%0d", i), v[i].e_req, v[i].e_addr, v[i].e_valid, v[i].e_pc, v[i].e_instr);
            @(posedge clk);
            #1;
        end

        // Redirect overrides a stall and flushes the held instruction.
        drive(0, 0, 0, 0, 0, 0, 1, 32'hCC);
        #3;
        check("seq ack req", {31'b0, IMemReq}, 32'd1);
        check("seq ack addr", IMemAddr, 32'h0040_0000);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 1, 32'h800, 1, 32'h0);
        #3;
        check_all("seq stall_jump", 0, 32'h0040_0004, 1, 32'h0040_0000, 32'hCC);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 0, 1, 32'hDD);
        #3;
        check_all("seq flushed", 1, 32'h800, 0, 32'h0040_0000, 32'hCC);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 0, 1, 32'hEE);
        #3;
        check_all("seq target", 0, 32'h804, 1, 32'h800, 32'hDD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
